// File: rtl/mult_8x8_seq_sched.sv
// mult_8x8_seq_sched: 8x8 approximate multiplier time-sharing one 4x4 iterative-log unit over up to 4 cycles
module mult_8x8_seq_sched #(
  parameter bit ZERO_SKIP = 1'b1,
  parameter bit DROP_LL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy,
  output logic [2:0]  steps
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [16:0] acc_q, acc_d, term;
  logic [3:0]  mask_q, mask_d, mask_clr, m_new;
  logic [15:0] r_q, r_d;
  logic [2:0]  steps_q, steps_d;
  logic [1:0]  sel;
  logic [3:0]  na, nb, sh;
  logic [7:0]  prod;
  logic        accept;

  function automatic logic [1:0] lod(input logic [3:0] x);
    lod = x[3] ? 2'd3 : x[2] ? 2'd2 : x[1] ? 2'd1 : 2'd0;
  endfunction

  // Mitchell-style term: 2^(kx+ky) + rx*2^ky + ry*2^kx, zero when an operand is zero
  function automatic logic [7:0] basic(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] kx, ky;
    logic [3:0] rx, ry;
    kx = lod(x);
    ky = lod(y);
    rx = x & ~(4'd1 << kx);
    ry = y & ~(4'd1 << ky);
    basic = (x == 4'd0 || y == 4'd0) ? 8'd0 :
            (8'd1 << ({1'b0, kx} + {1'b0, ky})) + ({4'd0, rx} << ky) + ({4'd0, ry} << kx);
  endfunction

  // LM_1_EC: basic term plus one error-compensation term built from the residues
  function automatic logic [7:0] lm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] rx, ry;
    rx = x & ~(4'd1 << lod(x));
    ry = y & ~(4'd1 << lod(y));
    lm4 = basic(x, y) + basic(rx, ry);
  endfunction

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign R         = r_q;
  assign steps     = steps_q;

  assign m_new[0] = !DROP_LL && (!ZERO_SKIP || (|A[3:0] && |B[3:0]));
  assign m_new[1] = !ZERO_SKIP || (|A[3:0] && |B[7:4]);
  assign m_new[2] = !ZERO_SKIP || (|A[7:4] && |B[3:0]);
  assign m_new[3] = !ZERO_SKIP || (|A[7:4] && |B[7:4]);

  assign sel      = mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : mask_q[2] ? 2'd2 : 2'd3;
  assign na       = sel[1] ? a_q[7:4] : a_q[3:0];
  assign nb       = sel[0] ? b_q[7:4] : b_q[3:0];
  assign sh       = (sel == 2'd0) ? 4'd0 : (sel == 2'd3) ? 4'd8 : 4'd4;
  assign prod     = lm4(na, nb);
  assign term     = {9'd0, prod} << sh;
  assign mask_clr = mask_q & (mask_q - 4'd1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    r_d     = r_q;
    steps_d = steps_q;
    if (state_q == CALC) begin
      acc_d  = acc_q + term;
      mask_d = mask_clr;
      if (mask_clr == 4'd0) begin
        r_d     = acc_d[15:0];
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (accept) begin
      a_d     = A;
      b_d     = B;
      acc_d   = '0;
      mask_d  = m_new;
      steps_d = {2'd0, m_new[0]} + {2'd0, m_new[1]} + {2'd0, m_new[2]} + {2'd0, m_new[3]};
      state_d = (|m_new) ? CALC : DONE;
      r_d     = (|m_new) ? r_q : 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      r_q     <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      r_q     <= r_d;
      steps_q <= steps_d;
    end
  end
endmodule

// File: tb/tb_mult_8x8_seq_sched.sv
// tb_mult_8x8_seq_sched: directed checks on three parameterisations (default, no zero-skip, drop LL)
module tb_mult_8x8_seq_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  in_v = 3'b000;
  logic [2:0]  ir, ov, bz;
  logic [7:0]  a = 8'd0, b = 8'd0;
  logic        out_ready = 1'b0;
  logic [15:0] r [3];
  logic [2:0]  st [3];
  int n_asrt = 0, n_fail = 0;
  int lat;
  logic [15:0] r_hold;

  always #5 clk = ~clk;

  mult_8x8_seq_sched #(.ZERO_SKIP(1'b1), .DROP_LL(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_v[0]),
    .in_ready(ir[0]), .A(a), .B(b), .out_valid(ov[0]), .out_ready(out_ready), .R(r[0]), .busy(bz[0]), .steps(st[0]));
  mult_8x8_seq_sched #(.ZERO_SKIP(1'b0), .DROP_LL(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_v[1]),
    .in_ready(ir[1]), .A(a), .B(b), .out_valid(ov[1]), .out_ready(out_ready), .R(r[1]), .busy(bz[1]), .steps(st[1]));
  mult_8x8_seq_sched #(.ZERO_SKIP(1'b1), .DROP_LL(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_v[2]),
    .in_ready(ir[2]), .A(a), .B(b), .out_valid(ov[2]), .out_ready(out_ready), .R(r[2]), .busy(bz[2]), .steps(st[2]));

  function automatic int msb(input int x);
    msb = 0;
    for (int i = 0; i < 4; i++) if (x[i]) msb = i;
  endfunction

  function automatic int lin(input int x, input int y);
    int kx, ky;
    if (x == 0 || y == 0) return 0;
    kx = msb(x);
    ky = msb(y);
    return x * (1 << ky) + y * (1 << kx) - (1 << (kx + ky));
  endfunction

  function automatic int lm4_ref(input int x, input int y);
    if (x == 0 || y == 0) return 0;
    return lin(x, y) + lin(x - (1 << msb(x)), y - (1 << msb(y)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int w, input logic [7:0] av, input logic [7:0] bv, output int l);
    a = av;
    b = bv;
    in_v[w] = 1'b1;
    @(negedge clk);
    in_v[w] = 1'b0;
    a = 8'hA5;
    b = 8'h5A;
    l = 1;
    while (!ov[w] && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
    chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_R", {16'd0, r[0]}, 32'd0);
    chk("rst_busy", {31'd0, bz[0]}, 32'd0);
    chk("rst_steps", {29'd0, st[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // zero operand: no steps, result in one cycle
    issue(0, 8'h00, 8'h5A, lat);
    chk("zero_lat", lat, 1);
    chk("zero_steps", {29'd0, st[0]}, 32'd0);
    chk("zero_R", {16'd0, r[0]}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("zero_idle", {31'd0, ov[0]}, 32'd0);
    out_ready = 1'b0;
    issue(0, 8'h10, 8'h01, lat);
    chk("hl_lat", lat, 2);
    chk("hl_steps", {29'd0, st[0]}, 32'd1);
    chk("hl_R", {16'd0, r[0]}, 32'd16);
    chk("hl_R_model", {16'd0, r[0]}, lm4_ref(1, 1) << 4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    // all four steps, largest operands
    issue(1, 8'hFF, 8'hFF, lat);
    chk("ff_lat", lat, 5);
    chk("ff_steps", {29'd0, st[1]}, 32'd4);
    chk("ff_R", {16'd0, r[1]}, 32'hF3D8);
    chk("ff_R_model", {16'd0, r[1]}, (lm4_ref(15, 15) * 289) & 32'hFFFF);
    r_hold = r[1];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, ov[1]}, 32'd1);
      chk("bp_R", {16'd0, r[1]}, {16'd0, r_hold});
      chk("bp_in_ready", {31'd0, ir[1]}, 32'd0);
    end
    a = 8'h01;
    b = 8'h01;
    in_v[1] = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("handoff_in_ready", {31'd0, ir[1]}, 32'd1);
    @(negedge clk);
    in_v[1] = 1'b0;
    chk("handoff_busy", {31'd0, bz[1]}, 32'd1);
    chk("handoff_valid", {31'd0, ov[1]}, 32'd0);
    lat = 1;
    while (!ov[1] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("handoff_lat", lat, 5);
    chk("handoff_R", {16'd0, r[1]}, 32'd1);
    @(negedge clk);
    chk("handoff_idle", {31'd0, bz[1]}, 32'd0);
    out_ready = 1'b0;
    issue(2, 8'h33, 8'h33, lat);
    chk("dll_lat", lat, 4);
    chk("dll_steps", {29'd0, st[2]}, 32'd3);
    chk("dll_R", {16'd0, r[2]}, 32'd2592);
    out_ready = 1'b1;
    @(negedge clk);
    // reset during the second CALC cycle
    a = 8'hFF;
    b = 8'hFF;
    in_v[1] = 1'b1;
    @(negedge clk);
    in_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, bz[1]}, 32'd0);
    chk("abort_valid", {31'd0, ov[1]}, 32'd0);
    chk("abort_R", {16'd0, r[1]}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, ov[1]}, 32'd0);
    end
    out_ready = 1'b0;
    issue(1, 8'h02, 8'h03, lat);
    chk("post_lat", lat, 5);
    chk("post_steps", {29'd0, st[1]}, 32'd4);
    chk("post_R", {16'd0, r[1]}, 32'd6);
    chk("post_R_model", {16'd0, r[1]}, lm4_ref(2, 3));
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
